// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bw_in. One bit per cycle, LSB first; done pulses WIDTH+1 cycles after start is accepted.
// A start is ignored while busy. Reset asserts at once and is released in step with clk.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bw_in,
  output logic [WIDTH-1:0] d,
  output logic             bw_out,
  output logic             v,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic             bw_q, bw_d, bw_out_q, bw_out_d, v_q, v_d;
  logic             diff, bw_nxt;
  logic [1:0]       rst_sync_q;
  logic             rst;

  // Assert immediately, release after two clean clock edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  assign diff   = a_q[0] ^ b_q[0] ^ bw_q;
  assign bw_nxt = (~a_q[0] & b_q[0]) | (~a_q[0] & bw_q) | (b_q[0] & bw_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    bw_d     = bw_q;
    res_d    = res_q;
    d_d      = d_q;
    bw_out_d = bw_out_q;
    v_d      = v_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          bw_d    = bw_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bw_d  = bw_nxt;
        res_d = {diff, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        // On the last bit a_q[0]/b_q[0]/diff are the operand and result MSBs.
        if (cnt_q == LAST) begin
          state_d  = DONE;
          d_d      = {diff, res_q[WIDTH-1:1]};
          bw_out_d = bw_nxt;
          v_d      = (a_q[0] ^ b_q[0]) & (a_q[0] ^ diff);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bw_q     <= 1'b0;
      res_q    <= '0;
      d_q      <= '0;
      bw_out_q <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bw_q     <= bw_d;
      res_q    <= res_d;
      d_q      <= d_d;
      bw_out_q <= bw_out_d;
      v_q      <= v_d;
    end
  end

  assign d      = d_q;
  assign bw_out = bw_out_q;
  assign v      = v_q;
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): vector table plus restart/reset sequences.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk, reset, start, bw_in;
  logic [W-1:0] a, b, d;
  logic         bw_out, v, busy, done;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .bw_in(bw_in),
    .d(d), .bw_out(bw_out), .v(v), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d_e;
    logic         bo_e;
    logic         v_e;
  } vec_t;

  vec_t vecs[7];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Called at a negedge; returns negedges counted until done is seen (W+1 expected).
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                        output int lat);
    start = 1'b1; a = aa; b = bb; bw_in = bi;
    @(negedge clk);
    start = 1'b0; a = ~aa; b = ~bb; bw_in = ~bi;
    lat = 1;
    check("busy_in_shift", int'(busy), 1);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    vecs[0] = '{4'd7,  4'd3,  1'b0, 4'd4,  1'b0, 1'b0};
    vecs[1] = '{4'd3,  4'd7,  1'b0, 4'd12, 1'b1, 1'b0};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
    vecs[3] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
    vecs[4] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    vecs[5] = '{4'd7,  4'd8,  1'b0, 4'd15, 1'b1, 1'b1};
    vecs[6] = '{4'd4,  4'd2,  1'b1, 4'd1,  1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; bw_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_d", int'(d), 0);
    check("rst_bw_out", int'(bw_out), 0);
    check("rst_v", int'(v), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, lat);
      check($sformatf("vec%0d_latency", i), lat, W + 1);
      check($sformatf("vec%0d_d", i), int'(d), int'(vecs[i].d_e));
      check($sformatf("vec%0d_bw_out", i), int'(bw_out), int'(vecs[i].bo_e));
      check($sformatf("vec%0d_v", i), int'(v), int'(vecs[i].v_e));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), int'(done), 0);
      check($sformatf("vec%0d_d_hold", i), int'(d), int'(vecs[i].d_e));
    end

    // Start during SHIFT is ignored, then a back-to-back start from the DONE cycle.
    start = 1'b1; a = 4'd5; b = 4'd2; bw_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd9;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_latency", lat, W + 1);
    check("ign_d", int'(d), 3);
    check("ign_bw_out", int'(bw_out), 0);
    run_op(4'd2, 4'd5, 1'b0, lat);
    check("b2b_latency", lat, W + 1);
    check("b2b_d", int'(d), 13);
    check("b2b_bw_out", int'(bw_out), 1);
    @(negedge clk);

    // Reset mid-SHIFT aborts with no done pulse.
    start = 1'b1; a = 4'd7; b = 4'd3; bw_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_d", int'(d), 0);
    check("abort_bw_out", int'(bw_out), 0);
    check("abort_v", int'(v), 0);
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) ndone++;
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle_busy", int'(busy), 0);
    run_op(4'd6, 4'd6, 1'b0, lat);
    check("post_rst_latency", lat, W + 1);
    check("post_rst_d", int'(d), 0);
    check("post_rst_bw_out", int'(bw_out), 0);
    check("post_rst_v", int'(v), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
